demux_lane_router: RTL and testbench

//  Registered 1-to-NUM_LANES demultiplexer with valid/ready flow control.

---
 rtl/demux_lane_router.sv | 145 ++++++++++++++
 tb/tb_demux_lane_router.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_lane_router.sv
// Registered 1-to-NUM_LANES demux with valid/ready flow control.
// Optional macro DEMUX_DROP_CNT_EN adds a saturating drop_cnt output.
module demux_lane_router #(
  parameter int NUM_LANES = 31,
  parameter int DW        = 2,
  parameter int SW        = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SW-1:0]           sel,
  input  logic [DW-1:0]           in_data,
  output logic [NUM_LANES*DW-1:0] out_data,
  output logic [NUM_LANES-1:0]    out_valid,
  input  logic [NUM_LANES-1:0]    out_ready,
  input  logic                    flush,
  input  logic                    clr_err,
  output logic                    err_bad_sel,
`ifdef DEMUX_DROP_CNT_EN
  output logic [7:0]              drop_cnt,
`endif
  output logic                    busy
);

  localparam int          SELN    = 2 ** SW;
  localparam logic [SW:0] LANES_W = (SW + 1)'(NUM_LANES);

  logic [NUM_LANES-1:0]    valid_q, valid_d;
  logic [NUM_LANES*DW-1:0] data_q, data_d;
  logic                    err_q, err_d;
  logic [NUM_LANES-1:0]    hit;
  logic [SELN-1:0]         stall_pad;
  logic                    sel_ok;
  logic                    accept;
  logic                    bad_acc;

  // Select is in range only below NUM_LANES
  assign sel_ok = {1'b0, sel} < LANES_W;

  // Lanes that hold a beat nobody is taking, padded to full select range
  always_comb begin
    stall_pad = '0;
    stall_pad[NUM_LANES-1:0] = valid_q & ~out_ready;
  end

  assign in_ready = ~flush & (~sel_ok | ~stall_pad[sel]);
  assign accept   = in_valid & in_ready;
  assign bad_acc  = accept & ~sel_ok;

  // One-hot lane load strobes
  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      hit[k] = accept & sel_ok & (sel == SW'(k));
    end
  end

  // Flush clears all; a load keeps the lane full; a taken beat drains
  always_comb begin
    valid_d = flush ? '0 : (hit | (valid_q & ~out_ready));
  end

  // Payload changes only on a load into that lane
  always_comb begin
    data_d = data_q;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (hit[k]) begin
        data_d[k*DW +: DW] = in_data;
      end
    end
  end

  // Sticky bad-select flag, set beats clear
  always_comb begin
    err_d = err_q;
    if (bad_acc) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  // Lane valid and payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Error flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  localparam int CW = $clog2(NUM_LANES + 1);

  logic [CW-1:0] pop;
  logic [8:0]    cnt_sum;
  logic [7:0]    cnt_q, cnt_d;

  // Number of held beats a flush throws away
  always_comb begin
    pop = '0;
    if (flush) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        pop = pop + CW'(valid_q[k]);
      end
    end
  end

  // Clear restarts from zero but still counts this cycle's drops
  always_comb begin
    cnt_sum = {1'b0, (clr_err ? 8'd0 : cnt_q)}
            + 9'(pop) + 9'(bad_acc);
    cnt_d   = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  // Saturating drop counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign drop_cnt = cnt_q;
`endif

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign err_bad_sel = err_q;
  assign busy        = |valid_q;

endmodule

// File: tb/tb_demux_lane_router.sv
// Self-checking bench for demux_lane_router.
// Scoreboard queue holds beats expected on lanes.
module tb_demux_lane_router;

  localparam int NL = 31;
  localparam int DW = 2;
  localparam int SW = 5;

  typedef struct {
    int          lane;
    logic [DW-1:0] data;
  } beat_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [SW-1:0]     sel;
  logic [DW-1:0]     in_data;
  logic [NL*DW-1:0]  out_data;
  logic [NL-1:0]     out_valid;
  logic [NL-1:0]     out_ready;
  logic              flush;
  logic              clr_err;
  logic              err_bad_sel;
  logic              busy;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0]        drop_cnt;
`endif

  int errs;
  int checks;
  beat_t sb[$];
  logic [NL*DW-1:0] exp_data;

  demux_lane_router #(.NUM_LANES(NL), .DW(DW), .SW(SW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sel(sel),
    .in_data(in_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .flush(flush),
    .clr_err(clr_err),
    .err_bad_sel(err_bad_sel),
`ifdef DEMUX_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int lane, input logic [DW-1:0] d);
    beat_t b;
    b.lane = lane;
    b.data = d;
    sb.push_back(b);
    exp_data[lane*DW +: DW] = d;
  endtask

  task automatic pop_check(input string nm, input logic [NL-1:0] vmask);
    beat_t b;
    logic [NL-1:0] ev;
    checks++;
    if (sb.size() == 0) begin
      errs++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      b = sb.pop_front();
      ev = vmask;
      ev[b.lane] = 1'b1;
      if (out_valid !== ev) begin
        errs++;
        $display("FAIL %s valid: got %h want %h", nm, out_valid, ev);
      end
      checks++;
      if (out_data[b.lane*DW +: DW] !== b.data) begin
        errs++;
        $display("FAIL %s data lane %0d: got %b want %b",
                 nm, b.lane, out_data[b.lane*DW +: DW], b.data);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (out_valid !== '0 || out_data !== '0 || err_bad_sel !== 1'b0) begin
      errs++;
      $display("FAIL reset_init: v=%h d=%h e=%b want 0", out_valid, out_data, err_bad_sel);
    end
    step();
    rst_n = 1'b1;
    exp_data = '0;
    step();
    sel = 5'd3; in_data = 2'b11; in_valid = 1'b1;
    push(3, 2'b11);
    step();
    in_valid = 1'b0;
    pop_check("reset_pre", '0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== '0 || out_data !== '0 || err_bad_sel !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_async: v=%h d=%h e=%b b=%b want 0", out_valid, out_data, err_bad_sel, busy);
    end
    exp_data = '0;
    step();
    rst_n = 1'b1;
    sel = 5'd4; in_data = 2'b01; in_valid = 1'b1;
    push(4, 2'b01);
    step();
    in_valid = 1'b0;
    pop_check("reset_first_accept", '0);
    out_ready = '1;
    step();
    out_ready = '0;
    checks++;
    if (out_valid !== '0) begin
      errs++;
      $display("FAIL reset_drain: got %h want 0", out_valid);
    end
  endtask

  task automatic test_route();
    sel = 5'd12; in_data = 2'b10; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL route_ready: got %b want 1", in_ready);
    end
    push(12, 2'b10);
    step();
    in_valid = 1'b0;
    pop_check("route", '0);
    checks++;
    if (out_data[25:24] !== 2'b10 || out_data !== exp_data) begin
      errs++;
      $display("FAIL route_data: got %h want %h", out_data, exp_data);
    end
  endtask

  task automatic test_backpressure();
    logic [NL-1:0] m12;
    m12 = '0;
    m12[12] = 1'b1;
    sel = 5'd12; in_data = 2'b01; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL bp_stall: got %b want 0", in_ready);
    end
    step();
    checks++;
    if (out_data !== exp_data || out_valid !== m12) begin
      errs++;
      $display("FAIL bp_hold: d=%h v=%h want d=%h v=%h", out_data, out_valid, exp_data, m12);
    end
    out_ready[12] = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_release: got %b want 1", in_ready);
    end
    push(12, 2'b01);
    step();
    in_valid = 1'b0;
    pop_check("bp_nobubble", '0);
    step();
    checks++;
    if (out_valid !== '0 || busy !== 1'b0 || out_data !== exp_data) begin
      errs++;
      $display("FAIL bp_drain: v=%h b=%b d=%h want 0 0 %h", out_valid, busy, out_data, exp_data);
    end
    out_ready = '0;
  endtask

  task automatic test_bad_sel();
    sel = 5'd31; in_data = 2'b11; in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL bad_ready: got %b want 1", in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (err_bad_sel !== 1'b1 || out_valid !== '0 || out_data !== exp_data) begin
      errs++;
      $display("FAIL bad_accept: e=%b v=%h d=%h want 1 0 %h", err_bad_sel, out_valid, out_data, exp_data);
    end
`ifdef DEMUX_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin
      errs++;
      $display("FAIL bad_cnt: got %0d want 1", drop_cnt);
    end
`endif
    clr_err = 1'b1;
    step();
    checks++;
    if (err_bad_sel !== 1'b0) begin
      errs++;
      $display("FAIL bad_clr: got %b want 0", err_bad_sel);
    end
`ifdef DEMUX_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin
      errs++;
      $display("FAIL bad_cnt_clr: got %0d want 0", drop_cnt);
    end
`endif
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    clr_err = 1'b0;
    checks++;
    if (err_bad_sel !== 1'b1) begin
      errs++;
      $display("FAIL bad_set_wins: got %b want 1", err_bad_sel);
    end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checks++;
    if (err_bad_sel !== 1'b0) begin
      errs++;
      $display("FAIL bad_clr2: got %b want 0", err_bad_sel);
    end
  endtask

  task automatic test_flush();
    int lanes[3];
    logic [NL-1:0] acc;
    lanes = '{0, 5, 30};
    acc = '0;
    foreach (lanes[i]) begin
      sel = SW'(lanes[i]);
      in_data = DW'(i + 1);
      in_valid = 1'b1;
      push(lanes[i], DW'(i + 1));
      step();
      pop_check("flush_load", acc);
      acc[lanes[i]] = 1'b1;
    end
    sel = 5'd7; in_data = 2'b10; flush = 1'b1;
    out_ready[5] = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL flush_ready: got %b want 0", in_ready);
    end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = '0;
    checks++;
    if (out_valid !== '0 || out_data !== exp_data || busy !== 1'b0) begin
      errs++;
      $display("FAIL flush_clear: v=%h d=%h want 0 %h", out_valid, out_data, exp_data);
    end
`ifdef DEMUX_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd3) begin
      errs++;
      $display("FAIL flush_cnt: got %0d want 3", drop_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    out_ready = '1;
    for (int i = 0; i < NL; i++) begin
      d = DW'($urandom_range(0, 3));
      sel = SW'(i);
      in_data = d;
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errs++;
        $display("FAIL sweep_stall lane %0d: got %b want 1", i, in_ready);
      end
      push(i, d);
      step();
      pop_check("sweep", '0);
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== '0 || busy !== 1'b0 || out_data !== exp_data) begin
      errs++;
      $display("FAIL sweep_end: v=%h d=%h want 0 %h", out_valid, out_data, exp_data);
    end
    out_ready = '0;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sel = '0;
    in_data = '0;
    out_ready = '0;
    flush = 1'b0;
    clr_err = 1'b0;
    exp_data = '0;
    test_reset();
    test_route();
    test_backpressure();
    test_bad_sel();
    test_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
